// File: rtl/operand_sequencer_if.sv
// Control and address bundle between the operand sequencer and its controller.
// Signal names carry the sequencer's own direction view.
interface operand_sequencer_if;
    logic       start_i;
    logic       stop_i;
    logic       auto_i;
    logic       step_i;
    logic [2:0] addr_a_o;
    logic [2:0] addr_b_o;
    logic       pair_valid_o;
    logic       tick_o;
    logic [1:0] state_o;
    logic       done_o;

    modport slave (
        input  start_i, stop_i, auto_i, step_i,
        output addr_a_o, addr_b_o, pair_valid_o, tick_o, state_o, done_o
    );

    modport master (
        output start_i, stop_i, auto_i, step_i,
        input  addr_a_o, addr_b_o, pair_valid_o, tick_o, state_o, done_o
    );
endinterface

// File: rtl/operand_sequencer.sv
// Scans operand address pairs (a, b) in row-major order, either free-running off a
// prescaler tick or advanced one pair per debounced push-button edge.
module operand_sequencer #(
    parameter int unsigned DIV_MAX   = 24_999_999,
    parameter int unsigned ADDR_LAST = 6
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    operand_sequencer_if.slave  bus
);

    localparam int unsigned CntW   = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV_MAX);
    localparam logic [2:0]      Last   = 3'(ADDR_LAST);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      addr_a_q, addr_a_d;
    logic [2:0]      addr_b_q, addr_b_d;
    logic            pv_q, pv_d;
    logic            tick_q, tick_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            step_q1, step_q2, step_q3;
    logic            step_edge;
    logic            advance;

    assign step_edge = step_q2 & ~step_q3;

    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        pv_d     = 1'b0;
        cnt_d    = '0;
        advance  = 1'b0;
        tick_d   = (state_q == StRun) && (cnt_q == CntMax);

        case (state_q)
            StIdle, StDone: begin
                if (bus.start_i && !bus.stop_i) begin
                    addr_a_d = 3'd0;
                    addr_b_d = 3'd0;
                    pv_d     = 1'b1;
                    state_d  = bus.auto_i ? StRun : StPause;
                end
            end
            StRun: begin
                if (bus.stop_i) begin
                    state_d = StPause;
                end else begin
                    cnt_d   = tick_d ? '0 : cnt_q + 1'b1;
                    advance = tick_d;
                end
            end
            StPause: begin
                // start wins over a coincident step edge; the step is simply lost
                if (!bus.stop_i) begin
                    if (bus.start_i) begin
                        if (bus.auto_i) state_d = StRun;
                    end else begin
                        advance = step_edge;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (advance) begin
            if (addr_a_q == Last && addr_b_q == Last) begin
                state_d = StDone;
            end else begin
                pv_d = 1'b1;
                if (addr_b_q == Last) begin
                    addr_b_d = 3'd0;
                    addr_a_d = addr_a_q + 3'd1;
                end else begin
                    addr_b_d = addr_b_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            addr_a_q <= 3'd0;
            addr_b_q <= 3'd0;
            pv_q     <= 1'b0;
            tick_q   <= 1'b0;
            cnt_q    <= '0;
            step_q1  <= 1'b0;
            step_q2  <= 1'b0;
            step_q3  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            pv_q     <= pv_d;
            tick_q   <= tick_d;
            cnt_q    <= cnt_d;
            step_q1  <= bus.step_i;
            step_q2  <= step_q1;
            step_q3  <= step_q2;
        end
    end

    assign bus.addr_a_o     = addr_a_q;
    assign bus.addr_b_o     = addr_b_q;
    assign bus.pair_valid_o = pv_q;
    assign bus.tick_o       = tick_q;
    assign bus.state_o      = state_q;
    assign bus.done_o       = (state_q == StDone);

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench: main scan instance (DIV_MAX=3, ADDR_LAST=6) plus two boundary
// instances (ADDR_LAST=0 and ADDR_LAST=7).
module tb_operand_sequencer;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pv_cnt  = 0;
    int   b7_cnt  = 0;
    int   base;

    operand_sequencer_if sq ();
    operand_sequencer_if b0 ();
    operand_sequencer_if b7 ();

    operand_sequencer #(.DIV_MAX(3), .ADDR_LAST(6)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (sq.slave)
    );

    operand_sequencer #(.DIV_MAX(1), .ADDR_LAST(0)) u_dut_b0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (b0.slave)
    );

    operand_sequencer #(.DIV_MAX(0), .ADDR_LAST(7)) u_dut_b7 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (b7.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sq.pair_valid_o) pv_cnt++;
        if (b7.pair_valid_o) b7_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        sq.start_i = 0; sq.stop_i = 0; sq.auto_i = 0; sq.step_i = 0;
        b0.start_i = 0; b0.stop_i = 0; b0.auto_i = 0; b0.step_i = 0;
        b7.start_i = 0; b7.stop_i = 0; b7.auto_i = 0; b7.step_i = 0;

        #2;
        check_eq("rst_state", 32'(sq.state_o), 0);
        check_eq("rst_addr_a", 32'(sq.addr_a_o), 0);
        check_eq("rst_addr_b", 32'(sq.addr_b_o), 0);
        check_eq("rst_pv", 32'(sq.pair_valid_o), 0);
        check_eq("rst_tick", 32'(sq.tick_o), 0);
        check_eq("rst_done", 32'(sq.done_o), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check_eq("idle_hold", 32'(sq.state_o), 0);

        // Auto scan of all 49 pairs
        base = pv_cnt;
        sq.start_i = 1; sq.auto_i = 1;
        cyc(1);
        sq.start_i = 0;
        check_eq("auto_state", 32'(sq.state_o), 1);
        check_eq("auto_first_pv", 32'(sq.pair_valid_o), 1);
        check_eq("auto_first_b", 32'(sq.addr_b_o), 0);
        for (int k = 1; k < 49; k++) begin
            cyc(3);
            check_eq("auto_gap_pv", 32'(sq.pair_valid_o), 0);
            cyc(1);
            check_eq("auto_pv", 32'(sq.pair_valid_o), 1);
            check_eq("auto_a", 32'(sq.addr_a_o), 32'(k / 7));
            check_eq("auto_b", 32'(sq.addr_b_o), 32'(k % 7));
            if (k == 1) check_eq("auto_tick", 32'(sq.tick_o), 1);
        end
        cyc(4);
        check_eq("done_state", 32'(sq.state_o), 3);
        check_eq("done_flag", 32'(sq.done_o), 1);
        check_eq("done_pv", 32'(sq.pair_valid_o), 0);
        check_eq("done_a", 32'(sq.addr_a_o), 6);
        check_eq("done_b", 32'(sq.addr_b_o), 6);
        cyc(3);
        check_eq("auto_pulses", 32'(pv_cnt - base), 49);

        // start in DONE, manual mode
        sq.start_i = 1; sq.auto_i = 0;
        cyc(1);
        sq.start_i = 0;
        check_eq("restart_state", 32'(sq.state_o), 2);
        check_eq("restart_pv", 32'(sq.pair_valid_o), 1);
        check_eq("restart_a", 32'(sq.addr_a_o), 0);
        check_eq("restart_b", 32'(sq.addr_b_o), 0);

        // Manual steps: each lands 3 clocks after the rise
        for (int s = 1; s <= 3; s++) begin
            sq.step_i = 1;
            cyc(2);
            check_eq("step_early_b", 32'(sq.addr_b_o), 32'(s - 1));
            cyc(1);
            check_eq("step_b", 32'(sq.addr_b_o), 32'(s));
            check_eq("step_pv", 32'(sq.pair_valid_o), 1);
            sq.step_i = 0;
            cyc(3);
        end
        sq.step_i = 1;
        cyc(3);
        check_eq("held_b", 32'(sq.addr_b_o), 4);
        cyc(17);
        check_eq("held_b_once", 32'(sq.addr_b_o), 4);
        check_eq("held_a", 32'(sq.addr_a_o), 0);
        sq.step_i = 0;
        cyc(3);

        // Pause/resume at (2,3)
        sq.start_i = 1; sq.auto_i = 1;
        cyc(1);
        sq.start_i = 0;
        check_eq("resume_state", 32'(sq.state_o), 1);
        check_eq("resume_no_pv", 32'(sq.pair_valid_o), 0);
        cyc(52);
        check_eq("pre_stop_a", 32'(sq.addr_a_o), 2);
        check_eq("pre_stop_b", 32'(sq.addr_b_o), 3);
        sq.stop_i = 1;
        cyc(1);
        sq.stop_i = 0;
        check_eq("stop_state", 32'(sq.state_o), 2);
        cyc(10);
        check_eq("pause_hold_b", 32'(sq.addr_b_o), 3);
        check_eq("pause_tick", 32'(sq.tick_o), 0);
        sq.start_i = 1; sq.auto_i = 1;
        cyc(1);
        sq.start_i = 0;
        check_eq("rerun_state", 32'(sq.state_o), 1);
        cyc(3);
        check_eq("rerun_early_b", 32'(sq.addr_b_o), 3);
        cyc(1);
        check_eq("rerun_a", 32'(sq.addr_a_o), 2);
        check_eq("rerun_b", 32'(sq.addr_b_o), 4);
        check_eq("rerun_pv", 32'(sq.pair_valid_o), 1);

        // stop coincident with tick: no advance
        cyc(3);
        sq.stop_i = 1;
        cyc(1);
        sq.stop_i = 0;
        check_eq("stoptick_state", 32'(sq.state_o), 2);
        check_eq("stoptick_b", 32'(sq.addr_b_o), 4);
        check_eq("stoptick_pv", 32'(sq.pair_valid_o), 0);

        // Reset mid-run at (4,5), asserted between edges
        sq.start_i = 1; sq.auto_i = 1;
        cyc(1);
        sq.start_i = 0;
        cyc(60);
        check_eq("prerst_a", 32'(sq.addr_a_o), 4);
        check_eq("prerst_b", 32'(sq.addr_b_o), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_state", 32'(sq.state_o), 0);
        check_eq("midrst_a", 32'(sq.addr_a_o), 0);
        check_eq("midrst_b", 32'(sq.addr_b_o), 0);
        check_eq("midrst_pv", 32'(sq.pair_valid_o), 0);
        cyc(1);
        base = pv_cnt;
        rst_n = 1'b1;
        cyc(20);
        check_eq("postrst_pulses", 32'(pv_cnt - base), 0);
        check_eq("postrst_state", 32'(sq.state_o), 0);

        // ADDR_LAST = 0
        b0.start_i = 1; b0.auto_i = 1;
        cyc(1);
        b0.start_i = 0;
        check_eq("b0_pv", 32'(b0.pair_valid_o), 1);
        check_eq("b0_run", 32'(b0.state_o), 1);
        cyc(1);
        check_eq("b0_still_run", 32'(b0.state_o), 1);
        cyc(1);
        check_eq("b0_done", 32'(b0.state_o), 3);
        check_eq("b0_done_pv", 32'(b0.pair_valid_o), 0);

        // ADDR_LAST = 7, tick every clock
        base = b7_cnt;
        b7.start_i = 1; b7.auto_i = 1;
        cyc(1);
        b7.start_i = 0;
        check_eq("b7_first_pv", 32'(b7.pair_valid_o), 1);
        cyc(7);
        check_eq("b7_b_last", 32'(b7.addr_b_o), 7);
        cyc(1);
        check_eq("b7_wrap_a", 32'(b7.addr_a_o), 1);
        check_eq("b7_wrap_b", 32'(b7.addr_b_o), 0);
        cyc(55);
        check_eq("b7_end_a", 32'(b7.addr_a_o), 7);
        check_eq("b7_end_b", 32'(b7.addr_b_o), 7);
        cyc(1);
        check_eq("b7_done", 32'(b7.state_o), 3);
        cyc(2);
        check_eq("b7_pulses", 32'(b7_cnt - base), 64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
